// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-outstanding memory backend between the fetch (IF)
// and data (DM) ports, with alternating priority under contention and a WAIT timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_data,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_en,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_n;
    logic             owner_dm, owner_dm_n;
    logic             wr_q, wr_q_n;
    logic             skip, skip_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             err_n, if_done_n, dm_done_n;
    logic [15:0]      addr_n, wdata_n, if_data_n, dm_rdata_n;
    logic             grant_dm;

    // skip remembers that IF was passed over, so it wins the next tie.
    assign grant_dm = dm_en & (~if_req | ~skip);

    assign mem_rd   = (state == ISSUE) & ~wr_q;
    assign mem_wr   = (state == ISSUE) & wr_q;
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_en & ~dm_done;

    always_comb begin
        state_n    = state;
        owner_dm_n = owner_dm;
        wr_q_n     = wr_q;
        skip_n     = skip;
        cnt_n      = cnt;
        err_n      = err;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        if_data_n  = if_data;
        dm_rdata_n = dm_rdata;
        if_done_n  = 1'b0;
        dm_done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req | dm_en) begin
                    owner_dm_n = grant_dm;
                    cnt_n      = '0;
                    state_n    = ISSUE;
                    if (grant_dm) begin
                        addr_n  = dm_addr;
                        wdata_n = dm_wdata;
                        wr_q_n  = dm_wr;
                        skip_n  = if_req;
                    end else begin
                        addr_n  = if_addr;
                        wr_q_n  = 1'b0;
                        skip_n  = 1'b0;
                    end
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (mem_ack || cnt == CNT_LAST) begin
                    // A timed-out access still completes, returning zero data.
                    if (!mem_ack) err_n = 1'b1;
                    if (owner_dm) begin
                        dm_rdata_n = mem_ack ? mem_rdata : 16'h0000;
                        dm_done_n  = 1'b1;
                    end else begin
                        if_data_n  = mem_ack ? mem_rdata : 16'h0000;
                        if_done_n  = 1'b1;
                    end
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_dm  <= 1'b0;
            wr_q      <= 1'b0;
            skip      <= 1'b0;
            cnt       <= '0;
            err       <= 1'b0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            if_data   <= 16'h0000;
            dm_rdata  <= 16'h0000;
        end else begin
            state     <= state_n;
            owner_dm  <= owner_dm_n;
            wr_q      <= wr_q_n;
            skip      <= skip_n;
            cnt       <= cnt_n;
            err       <= err_n;
            if_done   <= if_done_n;
            dm_done   <= dm_done_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            if_data   <= if_data_n;
            dm_rdata  <= dm_rdata_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, each
// transaction checked against a transaction-level model of the arbiter's rules.
module tb_mem_arbiter;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_en, dm_wr, mem_ack;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [15:0] if_data, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, if_stall, dm_done, dm_stall, mem_rd, mem_wr, err;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: whether IF is owed the next tie, sticky error, last owner.
    bit m_if_owed = 1'b0;
    bit m_err = 1'b0;
    bit m_dm = 1'b0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data),
        .if_done(if_done), .if_stall(if_stall),
        .dm_en(dm_en), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_done"}, {15'b0, if_done}, 16'h0);
        check({tag, "_dm_done"}, {15'b0, dm_done}, 16'h0);
        check({tag, "_err"}, {15'b0, err}, {15'b0, m_err});
    endtask

    // One complete access granted in the current IDLE cycle; ack arrives in WAIT
    // cycle d (d > TO means never). Returns with the DUT in its RESP cycle.
    task automatic txn(input int d, input logic [15:0] rdat, input bit drop_mid);
        bit dm_w, ewr;
        logic [15:0] ea, ewd, edata;
        dm_w = dm_en && (!if_req || !m_if_owed);
        m_if_owed = dm_w && if_req;
        m_dm = dm_w;
        ea = dm_w ? dm_addr : if_addr;
        ewr = dm_w && dm_wr;
        ewd = dm_wdata;
        mem_ack = 1'($urandom % 2);
        mem_rdata = 16'($urandom);
        tick();
        check("issue_rd", {15'b0, mem_rd}, {15'b0, !ewr});
        check("issue_wr", {15'b0, mem_wr}, {15'b0, ewr});
        check("issue_addr", mem_addr, ea);
        if (ewr) check("issue_wdata", mem_wdata, ewd);
        check_quiet("issue");
        mem_ack = 1'($urandom % 2);
        tick();
        for (int k = 1; k <= TO; k++) begin
            check_quiet("wait");
            check("wait_strobe", {14'b0, mem_rd, mem_wr}, 16'h0);
            if (drop_mid && k == 1) begin
                if (dm_w) dm_en = 1'b0; else if_req = 1'b0;
            end
            mem_ack = (k == d);
            mem_rdata = (k == d) ? rdat : 16'($urandom);
            tick();
            mem_ack = 1'b0;
            if (k == d) break;
        end
        if (d > TO) begin
            m_err = 1'b1;
            edata = 16'h0000;
        end else begin
            edata = rdat;
        end
        check("resp_if_done", {15'b0, if_done}, {15'b0, !dm_w});
        check("resp_dm_done", {15'b0, dm_done}, {15'b0, dm_w});
        if (!dm_w) check("resp_if_data", if_data, edata);
        else if (!ewr) check("resp_dm_rdata", dm_rdata, edata);
        check("resp_err", {15'b0, err}, {15'b0, m_err});
        check("resp_if_stall", {15'b0, if_stall}, {15'b0, if_req && dm_w});
        check("resp_dm_stall", {15'b0, dm_stall}, {15'b0, dm_en && !dm_w});
    endtask

    // Leave RESP (with a possible stray ack) and land in the following IDLE cycle.
    task automatic to_idle();
        mem_ack = 1'($urandom % 2);
        mem_rdata = 16'($urandom);
        tick();
        mem_ack = 1'($urandom % 2);
        check_quiet("idle");
    endtask

    task automatic idle_cycle();
        mem_ack = 1'($urandom % 2);
        tick();
        check_quiet("idle_only");
        check("idle_strobe", {14'b0, mem_rd, mem_wr}, 16'h0);
    endtask

    task automatic check_reset_values();
        check("rst_mem_rd", {15'b0, mem_rd}, 16'h0);
        check("rst_mem_wr", {15'b0, mem_wr}, 16'h0);
        check("rst_if_done", {15'b0, if_done}, 16'h0);
        check("rst_dm_done", {15'b0, dm_done}, 16'h0);
        check("rst_err", {15'b0, err}, 16'h0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_if_data", if_data, 16'h0);
        check("rst_dm_rdata", dm_rdata, 16'h0);
        check("rst_stalls", {14'b0, if_stall, dm_stall}, 16'h0);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; dm_en = 1'b0; dm_wr = 1'b0; mem_ack = 1'b0;
        if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0; mem_rdata = 16'h0;
        tick(); tick();
        check_reset_values();
        rst = 1'b0;

        // Single fetch
        if_req = 1'b1; if_addr = 16'h0010;
        txn(2, 16'hC0DE, 1'b0);
        if_req = 1'b0;
        to_idle();

        // Data write
        dm_en = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
        txn(1, 16'h1234, 1'b0);
        dm_en = 1'b0; dm_wr = 1'b0;
        to_idle();

        // Contention: DM, then IF, then DM again
        if_req = 1'b1; if_addr = 16'h00A0;
        dm_en = 1'b1; dm_addr = 16'h0200;
        txn(1, 16'h1111, 1'b0);
        to_idle();
        txn(2, 16'h2222, 1'b0);
        to_idle();
        txn(1, 16'h3333, 1'b0);
        if_req = 1'b0; dm_en = 1'b0;
        to_idle();

        // Minimum latency, then back-to-back regrant of a held request
        if_req = 1'b1; if_addr = 16'h0050;
        txn(1, 16'h0A0A, 1'b0);
        if_addr = 16'h0052;
        to_idle();
        txn(1, 16'h0B0B, 1'b0);
        if_req = 1'b0;
        to_idle();

        // Requester withdraws mid-transaction
        dm_en = 1'b1; dm_addr = 16'h0060;
        txn(3, 16'h6060, 1'b1);
        to_idle();

        // Timeout, then a normal access with err held
        if_req = 1'b1; if_addr = 16'h0070;
        txn(TO + 4, 16'hFFFF, 1'b0);
        if_addr = 16'h0072;
        to_idle();
        txn(2, 16'h5A5A, 1'b0);
        if_req = 1'b0;
        to_idle();

        // Reset mid-WAIT, late ack afterwards
        if_req = 1'b1; if_addr = 16'h0030;
        mem_ack = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; if_req = 1'b0;
        tick();
        check_reset_values();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        m_err = 1'b0; m_if_owed = 1'b0;
        tick();
        mem_ack = 1'b0;
        check_quiet("post_rst");
        check("post_rst_rd", {15'b0, mem_rd}, 16'h0);
        if_req = 1'b1; if_addr = 16'h0040;
        txn(1, 16'h4040, 1'b0);
        if_req = 1'b0;
        to_idle();

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            if (!if_req && ($urandom % 3 != 0)) begin
                if_req = 1'b1; if_addr = 16'($urandom);
            end
            if (!dm_en && ($urandom % 3 != 0)) begin
                dm_en = 1'b1; dm_wr = 1'($urandom % 2);
                dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
            end
            if (!if_req && !dm_en) begin
                idle_cycle();
                continue;
            end
            txn($urandom_range(1, TO + 3), 16'($urandom), 1'($urandom % 8 == 0));
            if ($urandom % 2 == 0) begin
                if (m_dm) dm_en = 1'b0; else if_req = 1'b0;
            end else if (m_dm) begin
                dm_wr = 1'($urandom % 2); dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
            end else begin
                if_addr = 16'($urandom);
            end
            to_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, max WAIT cycles without mem_ack before error recovery.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  fetch-stage read request, level, held until if_done.
REQ-005 if_addr  input  16  fetch address.
REQ-006 if_data  output  16  fetch read data, valid only while if_done=1.
REQ-007 if_done  output  1  one-cycle completion pulse for fetch.
REQ-008 if_stall  output  1  if_req & ~if_done.
REQ-009 dm_en  input  1  memory-stage access request, level, held until dm_done.
REQ-010 dm_wr  input  1  1=write, 0=read; sampled with dm_en.
REQ-011 dm_addr  input  16  data address.
REQ-012 dm_wdata  input  16  write data.
REQ-013 dm_rdata  output  16  data read value, valid only while dm_done=1.
REQ-014 dm_done  output  1  one-cycle completion pulse for data access.
REQ-015 dm_stall  output  1  dm_en & ~dm_done.
REQ-016 mem_addr  output  16  backend address, registered.
REQ-017 mem_wdata  output  16  backend write data, registered.
REQ-018 mem_rd  output  1  backend read strobe, one cycle.
REQ-019 mem_wr  output  1  backend write strobe, one cycle.
REQ-020 mem_rdata  input  16  backend read data, valid with mem_ack.
REQ-021 mem_ack  input  1  backend completion, one cycle.
REQ-022 err  output  1  sticky timeout error.

Function
REQ-023 FSM states IDLE, ISSUE, WAIT, RESP; owner register (IF/DM) and skip flag.
REQ-024 IDLE, no request: stay IDLE.
REQ-025 IDLE, request pending: latch owner, address, wdata, wr bit; next ISSUE.
REQ-026 Grant rule: DM wins if only DM pending or both pending with skip=0; IF wins if only IF pending or both pending with skip=1.
REQ-027 skip set when DM granted while if_req=1; cleared when IF granted.
REQ-028 ISSUE: exactly one of mem_rd/mem_wr high for one cycle (mem_wr only for DM with wr=1); next WAIT; mem_ack during ISSUE ignored.
REQ-029 WAIT: on mem_ack latch mem_rdata, next RESP; else increment wait counter.
REQ-030 WAIT counter reaching TIMEOUT without ack: set err, latch data 16'h0000, next RESP.
REQ-031 RESP: owner's done=1 one cycle with latched data on its data output; next IDLE.
REQ-032 Requests are not sampled in ISSUE, WAIT, RESP; input changes mid-transaction ignored.
REQ-033 Requester deasserting mid-transaction does not abort; done still pulses.
REQ-034 Write completion: dm_done pulses; dm_rdata value unspecified.
REQ-035 Minimum latency request-to-done = 3 cycles (grant t, ISSUE t+1, ack t+2, RESP t+3).
REQ-036 Back-to-back: request held through RESP granted in following IDLE cycle (one idle-cycle bubble).
REQ-037 mem_ack outside WAIT and other owner's done never asserted; mem_ack in IDLE/RESP does not set err.
REQ-038 err remains 1 until reset; arbiter continues operating after timeout.

Reset
REQ-039 On rst: state IDLE, skip=0, counter=0, err=0, mem_rd=mem_wr=0, if_done=dm_done=0, mem_addr=mem_wdata=if_data=dm_rdata=16'h0000.
REQ-040 rst in any state aborts in-flight transaction without done pulse; next cycle after reset deassert samples requests from IDLE.

Verification
REQ-041 Single fetch: if_req=1, if_addr=16'h0010, ack 2 cycles after ISSUE with 16'hC0DE -> mem_rd one cycle, mem_addr=16'h0010, if_done with if_data=16'hC0DE, if_stall low that cycle.
REQ-042 Contention: if_req and dm_en (read 16'h0200) rise together, held -> DM served first, IF served next, then with both still pending DM served (skip cleared).
REQ-043 Write: dm_en=1, dm_wr=1, addr 16'h0100, wdata 16'hBEEF -> mem_wr one cycle with those values, mem_rd=0, dm_done pulse.
REQ-044 Timeout: no mem_ack -> after 16 WAIT cycles err=1, requester done with data 16'h0000; subsequent access completes normally, err stays 1.
REQ-045 Reset mid-WAIT: rst during WAIT then late mem_ack -> no done pulse, err=0, outputs at reset values, next request granted normally.
REQ-046 Minimum latency: ack one cycle after ISSUE -> done exactly 3 cycles after request; held request regranted after one IDLE cycle.
